// File: rtl/stream_minmax_pkg.sv
// Shared types and constants for the stream_minmax frame statistics block.
package stream_minmax_pkg;

    localparam int unsigned SAMPLE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_res_t;

endpackage

// File: rtl/stream_minmax_cmp4.sv
// Unsigned 4-bit magnitude comparator: reports a==b, a>b and a<b.
module cmp4_unsigned
    import stream_minmax_pkg::*;
(
    input  logic [SAMPLE_W-1:0] a,
    input  logic [SAMPLE_W-1:0] b,
    output cmp_res_t            res_c
);

    always_comb begin
        res_c    = '0;
        res_c.eq = (a == b);
        res_c.gt = (a > b);
        res_c.lt = (a < b);
    end

endmodule

// File: rtl/stream_minmax.sv
// Per-frame max/min/count of a valid/ready sample stream, result held until taken.
// Optional equal-to-max counter enabled by defining STREAM_MINMAX_EQCNT_EN.
module stream_minmax
    import stream_minmax_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_max,
    output logic [SAMPLE_W-1:0] out_min,
    output logic [CNT_W-1:0]    out_cnt,
    output logic [CNT_W-1:0]    out_eqmax_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state, state_nxt;
    logic [SAMPLE_W-1:0] max_q, max_nxt;
    logic [SAMPLE_W-1:0] min_q, min_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic                in_ready_nxt, out_valid_nxt;
    logic                accept, take;
    cmp_res_t            cmp_max, cmp_min;
    logic                unused_cmp;

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    cmp4_unsigned u_cmp_max (
        .a     (in_data),
        .b     (max_q),
        .res_c (cmp_max)
    );

    cmp4_unsigned u_cmp_min (
        .a     (in_data),
        .b     (min_q),
        .res_c (cmp_min)
    );

    assign unused_cmp = ^{cmp_max.lt, cmp_max.eq, cmp_min.eq, cmp_min.gt};

    // Next-state and datapath update; handshake flags follow the next state.
    always_comb begin
        state_nxt = state;
        max_nxt   = max_q;
        min_nxt   = min_q;
        cnt_nxt   = cnt_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    max_nxt   = in_data;
                    min_nxt   = in_data;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (cmp_max.gt) max_nxt = in_data;
                    if (cmp_min.lt) min_nxt = in_data;
                    if (cnt_q != CNT_MAX) cnt_nxt = cnt_q + CNT_W'(1);
                    if (in_last) state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (take) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        in_ready_nxt  = (state_nxt != HOLD);
        out_valid_nxt = (state_nxt == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            max_q     <= '0;
            min_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            max_q     <= max_nxt;
            min_q     <= min_nxt;
            cnt_q     <= cnt_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    assign out_max = max_q;
    assign out_min = min_q;
    assign out_cnt = cnt_q;

`ifdef STREAM_MINMAX_EQCNT_EN
    logic [CNT_W-1:0] eq_q, eq_nxt;

    // Restart at 1 when a new max is established, count repeats of the current max.
    always_comb begin
        eq_nxt = eq_q;
        if (accept) begin
            if (state == IDLE || cmp_max.gt) begin
                eq_nxt = CNT_W'(1);
            end else if (cmp_max.eq && eq_q != CNT_MAX) begin
                eq_nxt = eq_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eq_q <= '0;
        end else begin
            eq_q <= eq_nxt;
        end
    end

    assign out_eqmax_cnt = eq_q;
`else
    assign out_eqmax_cnt = '0;
`endif

endmodule

// File: doc/stream_minmax.md
STREAM_MINMAX -- requirements
Module: stream_minmax

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of the sample counters.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  the input sample is valid.
REQ-005 SHALL have port in_ready  output  1  the block accepts the input sample.
REQ-006 SHALL have port in_data  input  4  the unsigned input sample.
REQ-007 SHALL have port in_last  input  1  marks the final sample of a frame.
REQ-008 SHALL have port out_valid  output  1  the frame result is available.
REQ-009 SHALL have port out_ready  input  1  the consumer accepts the result.
REQ-010 SHALL have port out_max  output  4  the largest sample in the frame.
REQ-011 SHALL have port out_min  output  4  the smallest sample in the frame.
REQ-012 SHALL have port out_cnt  output  CNT_W  the number of samples in the frame, saturating.
REQ-013 SHALL have port out_eqmax_cnt  output  CNT_W  the number of samples equal to the final max, saturating.

Function
REQ-014 SHALL treat a beat as accepted when in_valid and in_ready are both high on a rising clk edge.
REQ-015 SHALL treat the result as taken when out_valid and out_ready are both high on a rising clk edge.
REQ-016 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-017 SHALL drive in_ready=1 and out_valid=0 in IDLE and ACCUM, and in_ready=0 and out_valid=1 in HOLD.
REQ-018 SHALL, on the first accepted beat in IDLE, load max=min=in_data and cnt=1, then move to HOLD if in_last=1, otherwise to ACCUM.
REQ-019 SHALL, on each beat accepted in ACCUM, load max with in_data when in_data>max (strictly) and min with in_data when in_data<min (strictly).
REQ-020 SHALL, on each beat accepted in ACCUM, increment cnt saturating at 2^CNT_W-1.
REQ-021 SHALL, on a beat accepted in ACCUM with in_last=1, apply that beat's update and then move to HOLD.
REQ-022 SHALL assert out_valid in the cycle after the last beat is accepted (latency 1).
REQ-023 SHALL hold out_max, out_min, out_cnt and out_eqmax_cnt stable while out_valid=1 and out_ready=0.
REQ-024 SHALL move from HOLD to IDLE on the cycle the result is taken, so the next beat is accepted one cycle later.
REQ-025 SHALL keep state and outputs unchanged when in_valid=0 in IDLE or ACCUM.
REQ-026 SHALL ignore in_data and in_last when no beat is accepted.
REQ-027 SHALL evaluate all comparisons as unsigned 4-bit, with 4'hF as the largest and 4'h0 as the smallest value.

Reset
REQ-028 SHALL, when rst=1 at a clk edge, enter IDLE and clear max, min, cnt and eqmax_cnt to 0, so that out_valid=0, in_ready=1 and all data outputs read 0.
REQ-029 SHALL, on rst during ACCUM or HOLD, discard the partial frame or pending result with no output handshake.
REQ-030 SHALL give rst priority over any simultaneous handshake.

Configuration
REQ-031 SHALL use the macro STREAM_MINMAX_EQCNT_EN to select the equal-to-max counter.
REQ-032 SHALL, with STREAM_MINMAX_EQCNT_EN defined, set eqmax_cnt=1 on the first beat and whenever max is replaced, and increment it (saturating) when an accepted beat equals the current max.
REQ-033 SHALL, without STREAM_MINMAX_EQCNT_EN, keep the out_eqmax_cnt port and tie it to 0, with no counter logic.

Structure
REQ-034 SHALL place in the shared package stream_minmax_pkg: the state enum (IDLE, ACCUM, HOLD), the sample width constant (4), and a cmp_res_t struct {eq, gt, lt}.
REQ-035 SHALL instantiate twice a combinational sub-module cmp4_unsigned (inputs a[3:0] and b[3:0], output cmp_res_t): once for in_data against max, once for in_data against min.

Verification
REQ-036 SHALL cover: after rst, frame 6,2,9,9,4 (last on 4), out_ready=1 -> out_valid one cycle after the last beat; max=9, min=2, cnt=5, eqmax_cnt=2 (0 without the macro).
REQ-037 SHALL cover: single beat 7 with in_last=1 -> max=min=7, cnt=1, eqmax_cnt=1.
REQ-038 SHALL cover: frame 0,F, with out_ready held low 5 cycles -> in_ready=0 and outputs stable (max=F, min=0, cnt=2) until taken; IDLE and in_ready=1 the next cycle.
REQ-039 SHALL cover: CNT_W=2, frame of 6 beats of 3 -> cnt=3 (saturated), eqmax_cnt=3.
REQ-040 SHALL cover: rst pulsed after 3 beats of a frame -> no out_valid; the next frame 5,1 yields max=5, min=1, cnt=2.
REQ-041 SHALL cover: in_valid toggling 1,0,1,0 across frame 8,3 -> gaps do not change state; the result is max=8, min=3, cnt=2.
